// File: rtl/status_msg_pkg.sv
// Shared types and constants for the status message transmitter.
package status_msg_pkg;

  // Message kinds, listed in arbitration priority order.
  typedef enum logic [1:0] {
    MSG_FIM = 2'd0,
    MSG_BPM = 2'd1,
    MSG_BDM = 2'd2
  } msg_t;

  // Serialiser phases. LOAD belongs to the message sequencer; the byte
  // transmitter only walks IDLE -> START -> DATA -> STOP.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // Message sequencer control: waiting, fetching a byte, byte in flight.
  typedef enum logic [1:0] {
    CTL_IDLE = 2'd0,
    CTL_LOAD = 2'd1,
    CTL_SEND = 2'd2
  } ctl_t;

  // Message lengths in bytes.
  localparam logic [3:0] FIM_LEN = 4'd9;
  localparam logic [3:0] BPM_LEN = 4'd9;
  localparam logic [3:0] BDM_LEN = 4'd8;

  // ASCII characters used by the messages.
  localparam logic [7:0] A_B    = 8'h42;
  localparam logic [7:0] A_C    = 8'h43;
  localparam logic [7:0] A_D    = 8'h44;
  localparam logic [7:0] A_E    = 8'h45;
  localparam logic [7:0] A_F    = 8'h46;
  localparam logic [7:0] A_I    = 8'h49;
  localparam logic [7:0] A_M    = 8'h4D;
  localparam logic [7:0] A_P    = 8'h50;
  localparam logic [7:0] A_R    = 8'h52;
  localparam logic [7:0] A_S    = 8'h53;
  localparam logic [7:0] A_U    = 8'h55;
  localparam logic [7:0] A_0    = 8'h30;
  localparam logic [7:0] A_DASH = 8'h2D;
  localparam logic [7:0] A_HASH = 8'h23;

  // Index of the final byte of a message of the given kind.
  function automatic logic [3:0] msg_last_idx(input msg_t t);
    case (t)
      MSG_BPM: return BPM_LEN - 4'd1;
      MSG_BDM: return BDM_LEN - 4'd1;
      default: return FIM_LEN - 4'd1;
    endcase
  endfunction

  // Unit letter for a block-dropped code (1=R, 2=C, 3=E).
  function automatic logic [7:0] unit_char(input logic [1:0] code);
    case (code)
      2'd1:    return A_R;
      2'd2:    return A_C;
      default: return A_E;
    endcase
  endfunction

endpackage

// File: rtl/status_msg_tx_uart.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, one stop bit,
// each CLKS_PER_BIT cycles long. Accepts a byte when i_start is seen while
// o_ready is high; o_done marks the final cycle of the stop bit.
module uart_byte_tx
  import status_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              w_baud_last;

  assign w_baud_last = (r_baud == BAUD_LAST);
  assign o_ready     = (r_state == ST_IDLE);
  assign o_done      = (r_state == ST_STOP) && w_baud_last;
  assign o_tx        = r_tx;

  // Bit-timing state machine; the line level is registered so tx never glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          r_tx   <= 1'b1;
          if (i_start) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_baud_last) begin
            r_baud  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/status_msg_tx.sv
// Status message transmitter: detects FIM/BPM/BDM requests, holds one
// pending slot per message kind, and sends the winning message as ASCII
// over an 8N1 UART line.
module status_msg_tx
  import status_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_msg_fim,
  input  logic       send_msg_bpm,
  input  logic [2:0] send_msg_bdm,
  input  logic [2:0] su,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  // Request edge detection
  logic       r_fim_q;
  logic       r_bpm_q;
  logic [2:0] r_bdm_q;
  logic       w_fim_fire;
  logic       w_bpm_fire;
  logic       w_bdm_fire;

  // Pending slots and their captured fields
  logic       r_pend_fim;
  logic       r_pend_bpm;
  logic       r_pend_bdm;
  logic [2:0] r_su_fim;
  logic [2:0] r_su_bpm;
  logic [1:0] r_bdm_code;

  // Active message
  ctl_t       r_ctl;
  msg_t       r_act_type;
  logic [2:0] r_act_su;
  logic [1:0] r_act_code;
  logic [3:0] r_idx;
  logic       r_busy;

  // Byte transmitter interface
  logic [7:0] w_byte;
  logic       w_start;
  logic       w_ready;
  logic       w_byte_done;
  logic       w_last_byte;

  assign w_fim_fire  = send_msg_fim && !r_fim_q;
  assign w_bpm_fire  = send_msg_bpm && !r_bpm_q;
  assign w_bdm_fire  = (send_msg_bdm != r_bdm_q) && (send_msg_bdm != 3'd0) && !send_msg_bdm[2];

  assign w_start     = (r_ctl == CTL_LOAD) && w_ready;
  assign w_last_byte = (r_idx == msg_last_idx(r_act_type));
  assign busy        = r_busy;
  assign msg_done    = (r_ctl == CTL_SEND) && w_byte_done && w_last_byte;

  // Registered copies of the request inputs for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fim_q <= 1'b0;
      r_bpm_q <= 1'b0;
      r_bdm_q <= 3'd0;
    end else begin
      r_fim_q <= send_msg_fim;
      r_bpm_q <= send_msg_bpm;
      r_bdm_q <= send_msg_bdm;
    end
  end

  // Message sequencer with the pending queue; a new request wins over the
  // grant-clear in the same cycle so back-to-back requests are never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctl      <= CTL_IDLE;
      r_busy     <= 1'b0;
      r_idx      <= 4'd0;
      r_act_type <= MSG_FIM;
      r_act_su   <= 3'd0;
      r_act_code <= 2'd0;
      r_pend_fim <= 1'b0;
      r_pend_bpm <= 1'b0;
      r_pend_bdm <= 1'b0;
      r_su_fim   <= 3'd0;
      r_su_bpm   <= 3'd0;
      r_bdm_code <= 2'd0;
    end else begin
      case (r_ctl)
        CTL_IDLE: begin
          r_idx <= 4'd0;
          if (r_pend_fim) begin
            r_pend_fim <= 1'b0;
            r_act_type <= MSG_FIM;
            r_act_su   <= r_su_fim;
            r_busy     <= 1'b1;
            r_ctl      <= CTL_LOAD;
          end else if (r_pend_bpm) begin
            r_pend_bpm <= 1'b0;
            r_act_type <= MSG_BPM;
            r_act_su   <= r_su_bpm;
            r_busy     <= 1'b1;
            r_ctl      <= CTL_LOAD;
          end else if (r_pend_bdm) begin
            r_pend_bdm <= 1'b0;
            r_act_type <= MSG_BDM;
            r_act_code <= r_bdm_code;
            r_busy     <= 1'b1;
            r_ctl      <= CTL_LOAD;
          end
        end
        CTL_LOAD: begin
          if (w_ready) begin
            r_ctl <= CTL_SEND;
          end
        end
        CTL_SEND: begin
          if (w_byte_done) begin
            if (w_last_byte) begin
              r_idx  <= 4'd0;
              r_busy <= 1'b0;
              r_ctl  <= CTL_IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
              r_ctl <= CTL_LOAD;
            end
          end
        end
        default: begin
          r_busy <= 1'b0;
          r_ctl  <= CTL_IDLE;
        end
      endcase

      if (w_fim_fire) begin
        r_pend_fim <= 1'b1;
        r_su_fim   <= su;
      end
      if (w_bpm_fire) begin
        r_pend_bpm <= 1'b1;
        r_su_bpm   <= su;
      end
      if (w_bdm_fire) begin
        r_pend_bdm <= 1'b1;
        r_bdm_code <= send_msg_bdm[1:0];
      end
    end
  end

  // Byte selection for the active message and byte index.
  always_comb begin
    w_byte = A_HASH;
    case (r_act_type)
      MSG_FIM, MSG_BPM: begin
        case (r_idx)
          4'd0:    w_byte = (r_act_type == MSG_FIM) ? A_F : A_B;
          4'd1:    w_byte = (r_act_type == MSG_FIM) ? A_I : A_P;
          4'd2:    w_byte = A_M;
          4'd3:    w_byte = A_DASH;
          4'd4:    w_byte = A_S;
          4'd5:    w_byte = A_U;
          4'd6:    w_byte = A_0 + {5'd0, r_act_su};
          4'd7:    w_byte = A_DASH;
          default: w_byte = A_HASH;
        endcase
      end
      MSG_BDM: begin
        case (r_idx)
          4'd0:    w_byte = A_B;
          4'd1:    w_byte = A_D;
          4'd2:    w_byte = A_M;
          4'd3:    w_byte = A_DASH;
          4'd4:    w_byte = unit_char(r_act_code);
          4'd5:    w_byte = A_U;
          4'd6:    w_byte = A_DASH;
          default: w_byte = A_HASH;
        endcase
      end
      default: w_byte = A_HASH;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_start (w_start),
    .i_data  (w_byte),
    .o_ready (w_ready),
    .o_done  (w_byte_done),
    .o_tx    (tx)
  );

endmodule
